// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: condition encoding and
// a helper that classifies compare-against-zero branches.
package branch_pkg;

  localparam int COND_W = 3;

  typedef enum logic [COND_W-1:0] {
    COND_BEQ  = 3'd0,
    COND_BNE  = 3'd1,
    COND_BGTZ = 3'd2,
    COND_BLEZ = 3'd3,
    COND_BGEZ = 3'd4,
    COND_BLTZ = 3'd5
  } cond_e;

  // True for the four branches that compare rs against zero (rt ignored).
  function automatic logic cond_is_zero_cmp(input logic [COND_W-1:0] code);
    logic zero_cmp;
    case (cond_e'(code))
      COND_BGTZ, COND_BLEZ, COND_BGEZ, COND_BLTZ: zero_cmp = 1'b1;
      default:                                    zero_cmp = 1'b0;
    endcase
    return zero_cmp;
  endfunction

endpackage

// File: rtl/branch_operand_mux.sv
// Forwarding select for one branch operand. Register $0 is hard-wired to
// zero and never forwarded; EX beats MEM when both stages match.
module branch_operand_mux #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 fwd_ex_valid,
  input  logic [REG_IDX_W-1:0] fwd_ex_idx,
  input  logic [DATA_W-1:0]    fwd_ex_data,
  input  logic                 fwd_mem_valid,
  input  logic [REG_IDX_W-1:0] fwd_mem_idx,
  input  logic [DATA_W-1:0]    fwd_mem_data,
  output logic [DATA_W-1:0]    operand
);

  logic [DATA_W-1:0] operand_s;

  // Priority select: $0, then EX, then MEM, then register file.
  always_comb begin
    operand_s = {DATA_W{1'b0}};
    if (idx == {REG_IDX_W{1'b0}}) begin
      operand_s = {DATA_W{1'b0}};
    end else if (fwd_ex_valid && (fwd_ex_idx == idx)) begin
      operand_s = fwd_ex_data;
    end else if (fwd_mem_valid && (fwd_mem_idx == idx)) begin
      operand_s = fwd_mem_data;
    end else begin
      operand_s = reg_data;
    end
  end

  assign operand = operand_s;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver at the ID/EX boundary. Resolves the six MIPS
// compare-branches on forwarded operands and holds the decision in a
// single-entry valid/ready output register with flush support.
// Optional statistics counters: define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COND_W-1:0]    cond,
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic [REG_IDX_W-1:0] rt_idx,
  input  logic [DATA_W-1:0]    rs_data,
  input  logic [DATA_W-1:0]    rt_data,
  input  logic                 fwd_ex_valid,
  input  logic [REG_IDX_W-1:0] fwd_ex_idx,
  input  logic [DATA_W-1:0]    fwd_ex_data,
  input  logic                 fwd_mem_valid,
  input  logic [REG_IDX_W-1:0] fwd_mem_idx,
  input  logic [DATA_W-1:0]    fwd_mem_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_taken,
  output logic                 out_illegal,
  output logic [STAT_W-1:0]    stat_resolved,
  output logic [STAT_W-1:0]    stat_taken
);

  logic [DATA_W-1:0] s_op_s;
  logic [DATA_W-1:0] t_op_s;
  logic [DATA_W-1:0] rhs_s;
  logic              eq_s;
  logic              lt_s;
  logic              taken_s;
  logic              illegal_s;
  logic              accept_s;
  logic              out_valid_r;
  logic              out_taken_r;
  logic              out_illegal_r;

  branch_operand_mux #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_rs_mux (
    .idx           (rs_idx),
    .reg_data      (rs_data),
    .fwd_ex_valid  (fwd_ex_valid),
    .fwd_ex_idx    (fwd_ex_idx),
    .fwd_ex_data   (fwd_ex_data),
    .fwd_mem_valid (fwd_mem_valid),
    .fwd_mem_idx   (fwd_mem_idx),
    .fwd_mem_data  (fwd_mem_data),
    .operand       (s_op_s)
  );

  branch_operand_mux #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_rt_mux (
    .idx           (rt_idx),
    .reg_data      (rt_data),
    .fwd_ex_valid  (fwd_ex_valid),
    .fwd_ex_idx    (fwd_ex_idx),
    .fwd_ex_data   (fwd_ex_data),
    .fwd_mem_valid (fwd_mem_valid),
    .fwd_mem_idx   (fwd_mem_idx),
    .fwd_mem_data  (fwd_mem_data),
    .operand       (t_op_s)
  );

  // Single-entry buffer can take a new branch when empty or draining.
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // One signed comparator serves all conditions: zero-compares use 0 as rhs.
  always_comb begin
    if (cond_is_zero_cmp(cond)) begin
      rhs_s = {DATA_W{1'b0}};
    end else begin
      rhs_s = t_op_s;
    end
    eq_s      = (s_op_s == rhs_s);
    lt_s      = ($signed(s_op_s) < $signed(rhs_s));
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    case (cond_e'(cond))
      COND_BEQ:  taken_s = eq_s;
      COND_BNE:  taken_s = !eq_s;
      COND_BGTZ: taken_s = !lt_s && !eq_s;
      COND_BLEZ: taken_s = lt_s || eq_s;
      COND_BGEZ: taken_s = !lt_s;
      COND_BLTZ: taken_s = lt_s;
      default:   illegal_s = 1'b1;
    endcase
  end

  // Output register: flush beats accept, accept beats drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_taken_r   <= 1'b0;
      out_illegal_r <= 1'b0;
    end else if (flush) begin
      out_valid_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      out_taken_r   <= taken_s;
      out_illegal_r <= illegal_s;
    end else if (out_ready) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_taken   = out_taken_r;
  assign out_illegal = out_illegal_r;

`ifdef BRANCH_RESOLVE_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic              consume_s;
  logic [STAT_W-1:0] stat_resolved_r;
  logic [STAT_W-1:0] stat_taken_r;

  // A result discarded by a same-cycle flush does not count as consumed.
  assign consume_s = out_valid_r && out_ready && !flush;

  // Saturating counters of consumed and consumed-taken results.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_r <= {STAT_W{1'b0}};
      stat_taken_r    <= {STAT_W{1'b0}};
    end else if (consume_s) begin
      if (stat_resolved_r != STAT_MAX) begin
        stat_resolved_r <= stat_resolved_r + STAT_ONE;
      end
      if (out_taken_r && (stat_taken_r != STAT_MAX)) begin
        stat_taken_r <= stat_taken_r + STAT_ONE;
      end
    end else begin
      stat_resolved_r <= stat_resolved_r;
      stat_taken_r    <= stat_taken_r;
    end
  end

  assign stat_resolved = stat_resolved_r;
  assign stat_taken    = stat_taken_r;
`else
  assign stat_resolved = {STAT_W{1'b0}};
  assign stat_taken    = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (STAT_W = 2).
module tb_branch_resolve_unit;

  localparam int DW = 32;
  localparam int IW = 5;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    cond;
  logic [IW-1:0] rs_idx, rt_idx;
  logic [DW-1:0] rs_data, rt_data;
  logic          fwd_ex_valid;
  logic [IW-1:0] fwd_ex_idx;
  logic [DW-1:0] fwd_ex_data;
  logic          fwd_mem_valid;
  logic [IW-1:0] fwd_mem_idx;
  logic [DW-1:0] fwd_mem_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_taken;
  logic          out_illegal;
  logic [SW-1:0] stat_resolved;
  logic [SW-1:0] stat_taken;

  int n_assert = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.DATA_W(DW), .REG_IDX_W(IW), .STAT_W(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cond          (cond),
    .rs_idx        (rs_idx),
    .rt_idx        (rt_idx),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .fwd_ex_valid  (fwd_ex_valid),
    .fwd_ex_idx    (fwd_ex_idx),
    .fwd_ex_data   (fwd_ex_data),
    .fwd_mem_valid (fwd_mem_valid),
    .fwd_mem_idx   (fwd_mem_idx),
    .fwd_mem_data  (fwd_mem_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_taken     (out_taken),
    .out_illegal   (out_illegal),
    .stat_resolved (stat_resolved),
    .stat_taken    (stat_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs/outputs change away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] c, input logic [IW-1:0] rsi, input logic [IW-1:0] rti,
                         input logic [DW-1:0] rsd, input logic [DW-1:0] rtd);
    in_valid = 1'b1;
    cond     = c;
    rs_idx   = rsi;
    rt_idx   = rti;
    rs_data  = rsd;
    rt_data  = rtd;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cond = 3'd0; rs_idx = 5'd0; rt_idx = 5'd0;
    rs_data = 32'd0; rt_data = 32'd0; fwd_ex_valid = 1'b0; fwd_ex_idx = 5'd0;
    fwd_ex_data = 32'd0; fwd_mem_valid = 1'b0; fwd_mem_idx = 5'd0;
    fwd_mem_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_taken",   {31'd0, out_taken},   32'd0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_stat_r",  {30'd0, stat_resolved}, 32'd0);
    chk("rst_stat_t",  {30'd0, stat_taken},    32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // BEQ equal operands
    present(3'd0, 5'd1, 5'd2, 32'h0000_1234, 32'h0000_1234);
    tick(); in_valid = 1'b0; #1;
    chk("beq_valid",    {31'd0, out_valid}, 32'd1);
    chk("beq_taken",    {31'd0, out_taken}, 32'd1);
    chk("beq_in_ready", {31'd0, in_ready},  32'd1);
    tick();
    chk("beq_drained", {31'd0, out_valid}, 32'd0);

    // Sign boundaries, back to back
    present(3'd5, 5'd1, 5'd2, 32'h8000_0000, 32'h0000_0000); tick();
    chk("bltz_min", {31'd0, out_taken}, 32'd1);
    present(3'd4, 5'd1, 5'd2, 32'h8000_0000, 32'h0000_0000); tick();
    chk("bgez_min_valid", {31'd0, out_valid}, 32'd1);
    chk("bgez_min", {31'd0, out_taken}, 32'd0);
    present(3'd2, 5'd1, 5'd2, 32'h0000_0000, 32'h7FFF_FFFF); tick();
    chk("bgtz_zero", {31'd0, out_taken}, 32'd0);
    present(3'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h8000_0000); tick();
    chk("blez_zero", {31'd0, out_taken}, 32'd1);
    present(3'd4, 5'd1, 5'd2, 32'h0000_0000, 32'h0000_0001); tick();
    chk("bgez_zero", {31'd0, out_taken}, 32'd1);
    present(3'd5, 5'd1, 5'd2, 32'h0000_0000, 32'hFFFF_FFFF); tick();
    chk("bltz_zero", {31'd0, out_taken}, 32'd0);
    present(3'd2, 5'd1, 5'd2, 32'h0000_0001, 32'h0000_0005); tick();
    chk("bgtz_pos", {31'd0, out_taken}, 32'd1);
    present(3'd1, 5'd1, 5'd2, 32'h0000_0007, 32'h0000_0007); tick();
    chk("bne_equal", {31'd0, out_taken}, 32'd0);

    // Forwarding: EX priority over MEM
    fwd_ex_valid = 1'b1;  fwd_ex_idx = 5'd3;  fwd_ex_data = 32'd7;
    fwd_mem_valid = 1'b1; fwd_mem_idx = 5'd3; fwd_mem_data = 32'd9;
    present(3'd1, 5'd3, 5'd4, 32'd5, 32'd5); tick();
    chk("fwd_bne", {31'd0, out_taken}, 32'd1);
    present(3'd0, 5'd3, 5'd4, 32'd5, 32'd7); tick();
    chk("fwd_ex_prio", {31'd0, out_taken}, 32'd1);
    fwd_ex_valid = 1'b0;
    present(3'd0, 5'd3, 5'd4, 32'd5, 32'd9); tick();
    chk("fwd_mem_only", {31'd0, out_taken}, 32'd1);
    // Forwarding aimed at $0 must be ignored
    fwd_ex_valid = 1'b1;  fwd_ex_idx = 5'd0;  fwd_ex_data = 32'hFFFF_FFFF;
    fwd_mem_valid = 1'b1; fwd_mem_idx = 5'd0; fwd_mem_data = 32'hFFFF_FFFF;
    present(3'd0, 5'd0, 5'd0, 32'h0000_DEAD, 32'h0000_0055); tick();
    chk("r0_beq", {31'd0, out_taken}, 32'd1);
    present(3'd4, 5'd0, 5'd0, 32'h0000_DEAD, 32'h0000_0055); tick();
    chk("r0_bgez", {31'd0, out_taken}, 32'd1);
    in_valid = 1'b0; fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0;
    tick();

    // Back-pressure: result held stable, forwarding changes ignored
    out_ready = 1'b0;
    present(3'd1, 5'd1, 5'd2, 32'd1, 32'd2); tick();
    present(3'd0, 5'd1, 5'd2, 32'd1, 32'd2);
    fwd_ex_valid = 1'b1; fwd_ex_idx = 5'd2; fwd_ex_data = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready},  32'd0);
      chk("stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("stall_taken",    {31'd0, out_taken}, 32'd1);
      tick();
    end
    fwd_ex_valid = 1'b0;
    out_ready = 1'b1; #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0; #1;
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    chk("release_taken", {31'd0, out_taken}, 32'd0);
    tick();
    chk("release_drained", {31'd0, out_valid}, 32'd0);

    // Flush while full with a simultaneous accept
    out_ready = 1'b0;
    present(3'd0, 5'd1, 5'd2, 32'd4, 32'd4); tick();
    out_ready = 1'b1; flush = 1'b1;
    present(3'd0, 5'd1, 5'd2, 32'd6, 32'd6);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Undefined condition codes
    present(3'd7, 5'd1, 5'd2, 32'd3, 32'd3); tick();
    chk("c7_illegal", {31'd0, out_illegal}, 32'd1);
    chk("c7_taken",   {31'd0, out_taken},   32'd0);
    present(3'd6, 5'd1, 5'd2, 32'd3, 32'd3); tick();
    chk("c6_illegal", {31'd0, out_illegal}, 32'd1);
    present(3'd0, 5'd1, 5'd2, 32'd3, 32'd3); tick();
    chk("legal_again", {31'd0, out_illegal}, 32'd0);
    in_valid = 1'b0;

    // Reset while a result is held
    out_ready = 1'b0; tick();
    present(3'd0, 5'd1, 5'd2, 32'd8, 32'd8); tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_stat",  {30'd0, stat_resolved}, 32'd0);

    // Statistics: 5 consumed taken, 1 flushed unconsumed
    out_ready = 1'b1;
    present(3'd0, 5'd1, 5'd2, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; tick();
    out_ready = 1'b0;
    present(3'd0, 5'd1, 5'd2, 32'd1, 32'd1); tick();
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("stat_flushed_valid", {31'd0, out_valid}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_resolved_sat", {30'd0, stat_resolved}, 32'd3);
    chk("stat_taken_sat",    {30'd0, stat_taken},    32'd3);
`else
    chk("stat_resolved_tied", {30'd0, stat_resolved}, 32'd0);
    chk("stat_taken_tied",    {30'd0, stat_taken},    32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch-condition resolver for the pipelined MIPS core. Sits at the ID/EX boundary.
- Supports all six compare-branches: beq, bne, bgtz, blez, bgez, bltz.
- Selects operands from the register file or from EX/MEM forwarding paths.
- Registers the taken/not-taken decision behind a valid/ready handshake, with flush support for redirect.

Parameters:
- DATA_W, 32: operand width in bits; compare is two's-complement signed.
- REG_IDX_W, 5: register index width.
- STAT_W, 16: width of each statistics counter (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a branch is presented for resolution.
- in_ready  out  1  unit can accept a branch this cycle.
- cond  in  3  branch condition code (encoding in the package).
- rs_idx  in  REG_IDX_W  rs register index.
- rt_idx  in  REG_IDX_W  rt register index.
- rs_data  in  DATA_W  rs value from the register file.
- rt_data  in  DATA_W  rt value from the register file.
- fwd_ex_valid  in  1  EX-stage result is valid for forwarding.
- fwd_ex_idx  in  REG_IDX_W  EX-stage destination register.
- fwd_ex_data  in  DATA_W  EX-stage result value.
- fwd_mem_valid  in  1  MEM-stage result is valid for forwarding.
- fwd_mem_idx  in  REG_IDX_W  MEM-stage destination register.
- fwd_mem_data  in  DATA_W  MEM-stage result value.
- flush  in  1  pipeline redirect; discards held and incoming results.
- out_valid  out  1  a resolved result is held.
- out_ready  in  1  downstream consumes the result.
- out_taken  out  1  branch taken.
- out_illegal  out  1  cond code is undefined.
- stat_resolved  out  STAT_W  count of consumed results (optional feature).
- stat_taken  out  STAT_W  count of consumed taken results (optional feature).

Behaviour:
- Reset: out_valid=0, out_taken=0, out_illegal=0, stat_*=0. in_ready=1 on the first cycle after reset.
- Output register is single-entry, with implicit states EMPTY and FULL.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Latency is 1: the result appears on out_valid the cycle after accept.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + out_ready, no accept -> EMPTY.
  - FULL + out_ready + accept -> FULL with the new result; back-to-back throughput is 1 per cycle.
  - FULL + !out_ready -> hold out_taken and out_illegal stable.
- flush takes priority over everything: next cycle out_valid=0, and any same-cycle accept is dropped. in_ready is unaffected by flush.
- Operand select, per operand:
  - Index 0 always reads 0 and is never forwarded.
  - Else, EX forwarding if fwd_ex_valid and the index matches.
  - Else, MEM forwarding if fwd_mem_valid and the index matches.
  - Else, register-file data.
  - If EX and MEM both match, EX wins.
- Conditions (signed compare, width DATA_W):
  - BEQ: s==t.
  - BNE: s!=t.
  - BGTZ: s>0.
  - BLEZ: s<=0.
  - BGEZ: s>=0.
  - BLTZ: s<0.
  - rt is ignored for the four zero-compares.
  - Codes 6 and 7: out_taken=0, out_illegal=1.
- Boundaries:
  - s = most-negative value is <0, so BLTZ is taken and BGEZ is not.
  - s=0: BLEZ and BGEZ are taken; BGTZ and BLTZ are not.
- Operands are sampled only on accept; forwarding changes while FULL do not alter the held result.
- rst asserted mid-operation clears a held result immediately at the next edge.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- Defined:
  - stat_resolved increments on each out_valid && out_ready.
  - stat_taken increments additionally when out_taken is set at that handshake.
  - A flushed, unconsumed result is not counted.
  - Both counters saturate at all-ones; reset clears them to 0.
- Undefined: the stat_* ports are still present but tied to 0, and no counter flops are built.

Decomposition:
- Package branch_pkg holds:
  - cond_e typedef (3-bit): COND_BEQ=0, COND_BNE=1, COND_BGTZ=2, COND_BLEZ=3, COND_BGEZ=4, COND_BLTZ=5.
  - COND_W constant.
  - Helper function cond_is_zero_cmp.
- One sub-module, branch_operand_mux: combinational forwarding select, instantiated twice (rs and rt).

Test Plan:
- Reset, then BEQ with rs=rt=0x0000_1234, out_ready=1 -> out_valid=1, out_taken=1 one cycle after accept; in_ready stays 1.
- BLTZ with rs=0x8000_0000, then BGEZ with the same rs -> taken=1, then taken=0; BGTZ with rs=0 -> taken=0; BLEZ with rs=0 -> taken=1.
- BNE with rs_idx=3, rt_idx=4, both regfile=5:
  - EX forwards idx3=7 and MEM forwards idx3=9 -> EX priority, taken=1.
  - Forwarding to idx 0 with data 0xFFFF_FFFF, BEQ against $0 -> s=0, taken=1.
- Accept, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the output stays stable; release out_ready -> next branch is accepted in the same cycle.
- FULL with flush=1 and a simultaneous accept -> out_valid=0 next cycle, no result emitted; cond=7 -> out_illegal=1, taken=0.
- With BRANCH_RESOLVE_STATS_EN, STAT_W=2: 5 consumed taken branches plus 1 flushed -> stat_resolved=3 and stat_taken=3 (saturated).
